// File: rtl/approx_rca_pipe.sv
// approx_rca_pipe: pipelined ripple-carry adder with approximate LSB cells.
// Cells at bit positions below APPROX_BITS use the approximate cell
// (S = Y | Cin, Cout = ~Cin) unless exact_mode is set for the beat.
// The WIDTH-cell ripple chain is cut into STAGES equal segments. Segment k
// is computed in front of stage register k, so a result appears STAGES
// cycles after its beat is accepted.
//
// Handshake: a beat moves on an edge where valid & ready are both 1.
// adv = ~out_valid | out_ready advances every stage at once. in_ready is adv.
// When adv is 0 the whole pipe holds, and so does out_sum.
//
// Optional macro APPROX_ERR_MON_EN: carries an exact sum beside every beat
// and collects error statistics on delivered beats. Without the macro,
// err_count and err_max are tied to 0 and no exact-sum logic exists.
module approx_rca_pipe #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 2,
  parameter int STAGES      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             exact_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  input  logic             clr_stats,
  output logic [31:0]      err_count,
  output logic [WIDTH:0]   err_max
);

  localparam int SEG = WIDTH / STAGES;

  // Reject configurations the segmenting scheme cannot build.
  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("approx_rca_pipe: WIDTH out of range 4..64");
  end
  if (STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : g_bad_stages
    $error("approx_rca_pipe: STAGES must be 1..4 and divide WIDTH");
  end
  if (APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_bad_approx
    $error("approx_rca_pipe: APPROX_BITS out of range 0..WIDTH");
  end

  // One ripple segment. base is the absolute bit position of cell 0, so
  // cells keep approximate behaviour across segment boundaries.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           cin,
                                           input logic           exact,
                                           input int             base);
    logic           c;
    logic [SEG-1:0] s;
    c = cin;
    s = '0;
    for (int j = 0; j < SEG; j++) begin
      if (!exact && (base + j) < APPROX_BITS) begin
        s[j] = y[j] | c;
        c    = ~c;
      end else begin
        s[j] = x[j] ^ y[j] ^ c;
        c    = (x[j] & y[j]) | (x[j] & c) | (y[j] & c);
      end
    end
    return {c, s};
  endfunction

  // Stage registers
  logic             st_valid [STAGES];
  logic [WIDTH-1:0] st_a     [STAGES];
  logic [WIDTH-1:0] st_b     [STAGES];
  logic [WIDTH-1:0] st_sum   [STAGES];
  logic             st_c     [STAGES];
  logic             st_ex    [STAGES];

  // Stage inputs and next values
  logic             src_valid [STAGES];
  logic [WIDTH-1:0] src_a     [STAGES];
  logic [WIDTH-1:0] src_b     [STAGES];
  logic [WIDTH-1:0] src_sum   [STAGES];
  logic             src_c     [STAGES];
  logic             src_ex    [STAGES];
  logic [SEG:0]     seg_r     [STAGES];
  logic [WIDTH-1:0] nxt_sum   [STAGES];

  logic adv;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = st_valid[STAGES-1];
  assign out_sum   = {st_c[STAGES-1], st_sum[STAGES-1]};

  // Select each stage's source and compute its segment of the chain.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src_valid[k] = in_valid;
        src_a[k]     = in_a;
        src_b[k]     = in_b;
        src_sum[k]   = '0;
        src_c[k]     = 1'b0;
        src_ex[k]    = exact_mode;
      end else begin
        src_valid[k] = st_valid[k-1];
        src_a[k]     = st_a[k-1];
        src_b[k]     = st_b[k-1];
        src_sum[k]   = st_sum[k-1];
        src_c[k]     = st_c[k-1];
        src_ex[k]    = st_ex[k-1];
      end
      seg_r[k] = seg_add(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG],
                         src_c[k], src_ex[k], k * SEG);
      nxt_sum[k] = src_sum[k];
      nxt_sum[k][k*SEG +: SEG] = seg_r[k][SEG-1:0];
    end
  end

  // Pipeline registers: reset discards beats, adv=0 freezes every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st_valid[k] <= 1'b0;
        st_a[k]     <= '0;
        st_b[k]     <= '0;
        st_sum[k]   <= '0;
        st_c[k]     <= 1'b0;
        st_ex[k]    <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        st_valid[k] <= src_valid[k];
        st_a[k]     <= src_a[k];
        st_b[k]     <= src_b[k];
        st_sum[k]   <= nxt_sum[k];
        st_c[k]     <= seg_r[k][SEG];
        st_ex[k]    <= src_ex[k];
      end
    end
  end

`ifdef APPROX_ERR_MON_EN
  logic [WIDTH:0] st_x [STAGES];
  logic [WIDTH:0] exact_out;
  logic [WIDTH:0] abs_err;
  logic           deliver;

  assign exact_out = st_x[STAGES-1];
  assign deliver   = out_valid & out_ready;

  // Absolute distance between the delivered and exact sums.
  always_comb begin
    abs_err = '0;
    if (out_sum > exact_out) abs_err = out_sum - exact_out;
    else                     abs_err = exact_out - out_sum;
  end

  // The exact sum travels beside the beat, with the same stall behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) st_x[k] <= '0;
    end else if (adv) begin
      st_x[0] <= {1'b0, in_a} + {1'b0, in_b};
      for (int k = 1; k < STAGES; k++) st_x[k] <= st_x[k-1];
    end
  end

  // Statistics on delivered beats. A clear beats a simultaneous delivery.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      err_count <= '0;
      err_max   <= '0;
    end else if (deliver && (out_sum != exact_out)) begin
      if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
      if (abs_err > err_max) err_max <= abs_err;
    end
  end
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;
  assign err_count = '0;
  assign err_max   = '0;
`endif

endmodule

// File: doc/approx_rca_pipe.md
APPROX_RCA_PIPE -- requirements
Module: approx_rca_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, legal range 4..64.
REQ-002 Parameter APPROX_BITS, default 2: number of LSB positions using the approximate cell, legal range 0..WIDTH.
REQ-003 Parameter STAGES, default 2: number of pipeline register stages, legal range 1..4; WIDTH SHALL be divisible by STAGES.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_a, in_b  input  WIDTH each  addends.
REQ-009 exact_mode  input  1  1 = all cells exact for this beat.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  sink accepts the result.
REQ-012 out_sum  output  WIDTH+1  sum; MSB is final carry-out.
REQ-013 clr_stats  input  1  clears error statistics.
REQ-014 err_count  output  32  mismatching results delivered.
REQ-015 err_max  output  WIDTH+1  largest absolute error delivered.

Function
REQ-016 The adder SHALL be a ripple chain of WIDTH cells; carry-in of bit 0 SHALL be 0.
REQ-017 Cells at bit positions 0..APPROX_BITS-1 SHALL use the approximate cell when exact_mode=0: S = Y | Cin, Cout = ~Cin (X ignored).
REQ-018 All other cells, and all cells when exact_mode=1, SHALL be exact full adders: S = X^Y^Cin, Cout = majority(X,Y,Cin).
REQ-019 The chain SHALL be split into STAGES equal segments; segment k computed in stage k; inter-segment carry, unprocessed operand slices, computed sum slices and exact_mode SHALL be registered per stage.
REQ-020 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid=1 when out_ready stays 1.
REQ-021 Pipeline advance enable: adv = ~out_valid | out_ready; in_ready SHALL equal adv combinationally.
REQ-022 A beat SHALL be accepted only when in_valid & in_ready; when adv=0 every stage register SHALL hold its value (global stall, no bubble collapse).
REQ-023 Each stage SHALL carry a valid bit; bubbles propagate as invalid entries, and out_valid SHALL be the last stage's valid bit.
REQ-024 out_sum SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Throughput SHALL be one beat per cycle with out_ready held 1.

Reset
REQ-026 While rst_n=0 at a clock edge, all stage valid bits, out_valid, out_sum, err_count and err_max SHALL become 0; in-flight beats are discarded.
REQ-027 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-028 Macro APPROX_ERR_MON_EN SHALL compile in an error monitor: an exact WIDTH+1-bit sum travels alongside each beat; on each delivered beat (out_valid & out_ready) with mismatch, err_count increments, saturating at 0xFFFFFFFF; err_max updates to max(err_max, |approx-exact|).
REQ-029 clr_stats=1 SHALL zero both statistics next edge; if a delivered beat coincides, clear wins.
REQ-030 Without APPROX_ERR_MON_EN the ports SHALL remain present, driven constant 0, and no exact-sum logic SHALL exist; datapath behaviour is identical.

Verification
REQ-031 Defaults, a=0x0000, b=0x0000, exact_mode=0 -> out_sum=0x00002 after 2 cycles; err_count=1, err_max=2 (monitor on).
REQ-032 Defaults, a=0xFFFF, b=0x0001, exact_mode=0 -> out_sum=0x0FFFF; exact_mode=1 -> out_sum=0x10000; err_max=1 after both.
REQ-033 100 back-to-back beats, out_ready=1 -> 100 results in order, one per cycle, first 2 cycles after first accept.
REQ-034 out_ready=0 for 5 cycles mid-stream -> in_ready=0 after pipeline fills, out_sum stable, no beat lost or duplicated.
REQ-035 rst_n=0 for one cycle with 2 beats in flight -> out_valid=0 next cycle, statistics 0, no stale beat later emitted.
REQ-036 APPROX_BITS=0, 1000 random beats -> out_sum equals a+b on every beat, err_count=0.
